// File: rtl/inst_boot_loader_pkg.sv
// Shared types and widths for the instruction boot loader and its bench.
`timescale 1ns/1ps
package inst_boot_loader_pkg;

  localparam int CSUM_W = 8;   // running XOR checksum width
  localparam int CNT_W  = 16;  // header word-count width

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/inst_boot_loader_word_assembler.sv
// Collects little-endian bytes into a 32-bit word; flags the byte that completes it.
`timescale 1ns/1ps
module word_assembler (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_vld
);

  logic [1:0]  idx;
  logic [23:0] sh;

  // The 4th byte is combined on the fly so the top can register the write next cycle.
  assign word_vld = byte_vld && (idx == 2'd3);
  assign word_out = {byte_in, sh};

  // Shift right so the first byte ends up in bits [7:0]; clear drops a partial word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx <= 2'd0;
      sh  <= 24'd0;
    end else if (clear) begin
      idx <= 2'd0;
      sh  <= 24'd0;
    end else if (byte_vld) begin
      idx <= idx + 2'd1;
      sh  <= {byte_in, sh[23:8]};
    end
  end

endmodule

// File: rtl/inst_boot_loader.sv
// Byte-stream boot loader: header count, instruction words, XOR checksum, then CPU release.
`timescale 1ns/1ps
module inst_boot_loader
  import inst_boot_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd1,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        inst_sram_wen,
  output logic [63:0] inst_sram_waddr,
  output logic [31:0] inst_sram_wdata,
  output logic        inst_sram_en_toif,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_WORDS);

  state_t              state, state_nxt;
  logic                xfer;
  logic [7:0]          cnt_lo;
  logic [CNT_W-1:0]    hdr_cnt;
  logic [CNT_W-1:0]    word_tot;
  logic [CNT_W-1:0]    word_cnt;
  logic [CSUM_W-1:0]   csum;
  logic [31:0]         asm_word;
  logic                asm_vld;

  // Ready is gated by reset so nothing is offered while the loader is held.
  assign rx_ready = resetn && (state == S_HDR0 || state == S_HDR1 ||
                               state == S_DATA || state == S_CSUM);
  assign xfer     = rx_valid && rx_ready;
  assign hdr_cnt  = {rx_data, cnt_lo};

  word_assembler u_asm (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (state != S_DATA),
    .byte_vld (xfer && state == S_DATA),
    .byte_in  (rx_data),
    .word_out (asm_word),
    .word_vld (asm_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_HDR0;
    else         state <= state_nxt;
  end

  // Next-state and release/status outputs; only DONE lets go of the core.
  always_comb begin
    state_nxt         = state;
    cpu_reset         = 1'b1;
    inst_sram_en_toif = 1'b0;
    load_done         = 1'b0;
    load_err          = 1'b0;
    case (state)
      S_HDR0: if (xfer) state_nxt = S_HDR1;
      S_HDR1: if (xfer) begin
        if (hdr_cnt == '0)                   state_nxt = S_CSUM;
        else if ({1'b0, hdr_cnt} > MAX_CNT)  state_nxt = S_ERR;
        else                                 state_nxt = S_DATA;
      end
      S_DATA: if (asm_vld && (word_cnt + 16'd1 == word_tot)) state_nxt = S_CSUM;
      S_CSUM: if (xfer) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
      S_DONE: begin
        cpu_reset         = 1'b0;
        inst_sram_en_toif = 1'b1;
        load_done         = 1'b1;
      end
      S_ERR:   load_err  = 1'b1;
      default: state_nxt = S_HDR0;
    endcase
  end

  // Header capture, checksum, word counting and the registered SRAM write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_lo          <= '0;
      word_tot        <= '0;
      word_cnt        <= '0;
      csum            <= '0;
      inst_sram_wen   <= 1'b0;
      inst_sram_wdata <= '0;
      inst_sram_waddr <= BASE_ADDR;
    end else begin
      if (xfer && (state == S_HDR0 || state == S_HDR1 || state == S_DATA))
        csum <= csum ^ rx_data;
      if (xfer && state == S_HDR0) cnt_lo <= rx_data;
      if (xfer && state == S_HDR1) begin
        word_tot <= hdr_cnt;
        word_cnt <= '0;
      end
      inst_sram_wen <= asm_vld;
      if (asm_vld) begin
        inst_sram_wdata <= asm_word;
        word_cnt        <= word_cnt + 16'd1;
      end
      // Address advances once the current write has been presented.
      if (inst_sram_wen) inst_sram_waddr <= inst_sram_waddr + 64'd1;
    end
  end

endmodule

// File: tb/tb_inst_boot_loader.sv
// Bench for inst_boot_loader: vector table of load streams plus a mid-load reset sequence.
`timescale 1ns/1ps
module tb_inst_boot_loader;
  import inst_boot_loader_pkg::*;

  localparam logic [63:0] BASE = 64'd1;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, inst_sram_wen, inst_sram_en_toif, cpu_reset, load_done, load_err;
  logic [63:0] inst_sram_waddr;
  logic [31:0] inst_sram_wdata;

  inst_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .inst_sram_wen(inst_sram_wen), .inst_sram_waddr(inst_sram_waddr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_en_toif(inst_sram_en_toif),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned cnt;
    bit          bad;
    bit          rnd;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  wr_t   exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    n_wr  = 0;
  logic [31:0]       prog [4];
  logic [CSUM_W-1:0] xsum;
  vec_t  vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every write pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (inst_sram_wen === 1'b1) begin
      wr_t e;
      n_wr++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 inst_sram_waddr, inst_sram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", inst_sram_waddr, e.addr);
        chk("wdata", {32'd0, inst_sram_wdata}, {32'd0, e.data});
      end
    end
  end

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_wen", {63'd0, inst_sram_wen}, 64'd0);
    chk("rst_waddr", inst_sram_waddr, BASE);
    chk("rst_wdata", {32'd0, inst_sram_wdata}, 64'd0);
    chk("rst_en_toif", {63'd0, inst_sram_en_toif}, 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_load_done", {63'd0, load_done}, 64'd0);
    chk("rst_load_err", {63'd0, load_err}, 64'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    resetn   = 1'b0;
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;
    xsum   = '0;
  endtask

  // Offer one byte and wait for it to transfer; random idle gaps when rnd is set.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit rdy;
    bit ok;
    if (rnd) begin
      while ($urandom_range(1, 0) == 1) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge clk); rdy = rx_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL byte_timeout: got no transfer of %h expected transfer", b);
    end else begin
      xsum = xsum ^ b;
    end
  endtask

  task automatic send_words(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [31:0] w;
        w = prog[i];
        if (j == 3) exp_q.push_back('{addr: BASE + 64'(i), data: w});
        send_byte(w[8*j +: 8], rnd);
      end
    end
  endtask

  task automatic run_case(input int idx, input vec_t v);
    logic [15:0] c;
    logic [7:0]  cs;
    do_reset();
    exp_q.delete();
    n_wr = 0;
    c = v.cnt[15:0];
    send_byte(c[7:0], v.rnd);
    send_byte(c[15:8], v.rnd);
    if (v.cnt <= 4) begin
      send_words(int'(v.cnt), v.rnd);
      cs = xsum ^ (v.bad ? 8'hFF : 8'h00);
      send_byte(cs, v.rnd);
    end
    // First cycle after the final transfer: release (or error) must already show.
    @(negedge clk);
    chk($sformatf("c%0d_done", idx), {63'd0, load_done}, {63'd0, v.exp_done});
    chk($sformatf("c%0d_err", idx), {63'd0, load_err}, {63'd0, v.exp_err});
    chk($sformatf("c%0d_cpu_reset", idx), {63'd0, cpu_reset}, {63'd0, !v.exp_done});
    chk($sformatf("c%0d_en_toif", idx), {63'd0, inst_sram_en_toif}, {63'd0, v.exp_done});
    chk($sformatf("c%0d_rx_ready", idx), {63'd0, rx_ready}, 64'd0);
    chk($sformatf("c%0d_wen_off", idx), {63'd0, inst_sram_wen}, 64'd0);
    // Junk bytes afterwards must not move a final state.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    chk($sformatf("c%0d_sticky_done", idx), {63'd0, load_done}, {63'd0, v.exp_done});
    chk($sformatf("c%0d_sticky_err", idx), {63'd0, load_err}, {63'd0, v.exp_err});
    chk($sformatf("c%0d_n_writes", idx), 64'(n_wr), 64'(v.exp_wr));
    chk($sformatf("c%0d_pending", idx), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    prog[0] = 32'h01400113;
    prog[1] = 32'h00510193;
    prog[2] = 32'h00100A13;
    prog[3] = 32'h003A30A3;
    //           cnt       bad   rnd   done  err   writes
    vecs[0] = '{cnt: 4,        bad: 0, rnd: 0, exp_done: 1, exp_err: 0, exp_wr: 4};
    vecs[1] = '{cnt: 4,        bad: 1, rnd: 0, exp_done: 0, exp_err: 1, exp_wr: 4};
    vecs[2] = '{cnt: 0,        bad: 0, rnd: 0, exp_done: 1, exp_err: 0, exp_wr: 0};
    vecs[3] = '{cnt: MAXW + 1, bad: 0, rnd: 0, exp_done: 0, exp_err: 1, exp_wr: 0};
    vecs[4] = '{cnt: 4,        bad: 0, rnd: 1, exp_done: 1, exp_err: 0, exp_wr: 4};

    for (int k = 0; k < 5; k++) run_case(k, vecs[k]);

    // Reset after 6 data bytes: only the completed first word may be written.
    do_reset();
    exp_q.delete();
    n_wr = 0;
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_words(1, 1'b0);
    send_byte(prog[1][7:0], 1'b0);
    send_byte(prog[1][15:8], 1'b0);
    resetn = 1'b0;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    chk("midrst_n_writes", 64'(n_wr), 64'd1);
    chk("midrst_pending", 64'(exp_q.size()), 64'd0);
    run_case(5, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
